// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding
// select encoding (also used by the EX operand Mux3x1) and hazard FSM states.
package pipeline_hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN        = 1'b0,
        HZ_LOAD_STALL = 1'b1
    } hz_state_t;

    localparam int NUM_OPS   = 2;
    localparam int LS_CNT_W  = 4;

endpackage

// File: rtl/pipeline_hazard_sequencer_fwd_select.sv
// Per-operand EX forwarding select: MEM result beats WB result beats register file.
module pipeline_hazard_sequencer_fwd_select
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_ADDR_W-1:0] wa_mem,
    input  logic                  we_mem,
    input  logic [REG_ADDR_W-1:0] wa_wb,
    input  logic                  we_wb,
    output fwd_sel_t              sel
);

    logic hit_mem, hit_wb;

    assign hit_mem = we_mem && (ra == wa_mem) && !(ZERO_REG_HARDWIRED && (wa_mem == '0));
    assign hit_wb  = we_wb  && (ra == wa_wb)  && !(ZERO_REG_HARDWIRED && (wa_wb  == '0));

    always_comb begin
        sel = FWD_RF;
        if (hit_mem)     sel = FWD_MEM;
        else if (hit_wb) sel = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central hazard controller: stall/flush/forward controls, multi-cycle
// load-use stall sequencing and saturating stall/flush performance counters.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int CNT_W              = 16,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] ra1_2,
    input  logic [REG_ADDR_W-1:0] ra2_2,
    input  logic                  use_ra1_2,
    input  logic                  use_ra2_2,
    input  logic [REG_ADDR_W-1:0] ra1_3,
    input  logic [REG_ADDR_W-1:0] ra2_3,
    input  logic [REG_ADDR_W-1:0] wa3,
    input  logic                  reg_we3,
    input  logic                  mem_read3,
    input  logic [REG_ADDR_W-1:0] wa4,
    input  logic                  reg_we4,
    input  logic [REG_ADDR_W-1:0] wa5,
    input  logic                  reg_we5,
    input  logic                  redirect3,
    input  logic                  ext_stall,
    output logic                  stall_front,
    output logic                  stall_back,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam logic [LS_CNT_W-1:0] LS_RELOAD = LS_CNT_W'(LOAD_STALL_CYCLES - 2);

    hz_state_t             state;
    logic [LS_CNT_W-1:0]   ls_cnt;
    logic                  load_use, hz_stall;

    function automatic logic hit(input logic [REG_ADDR_W-1:0] x, input logic [REG_ADDR_W-1:0] w);
        return (x == w) && !(ZERO_REG_HARDWIRED && (w == '0));
    endfunction

    assign load_use = mem_read3 & reg_we3 &
                      ((use_ra1_2 & hit(ra1_2, wa3)) | (use_ra2_2 & hit(ra2_2, wa3)));
    assign hz_stall = (state == HZ_LOAD_STALL) | load_use;

    // Operand forwarding is state-independent; one selector per EX operand.
    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] ra_3;
    fwd_sel_t                           fwd_sel [NUM_OPS];

    assign ra_3 = {ra2_3, ra1_3};

    for (genvar op = 0; op < NUM_OPS; op++) begin : g_fwd
        pipeline_hazard_sequencer_fwd_select #(
            .REG_ADDR_W        (REG_ADDR_W),
            .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
        ) u_fwd (
            .ra    (ra_3[op]),
            .wa_mem(wa4),
            .we_mem(reg_we4),
            .wa_wb (wa5),
            .we_wb (reg_we5),
            .sel   (fwd_sel[op])
        );
    end

    assign fwd_a = RST ? FWD_RF : fwd_sel[0];
    assign fwd_b = RST ? FWD_RF : fwd_sel[1];

    // Priority: reset > freeze > redirect > load hazard.
    always_comb begin
        stall_front = 1'b0;
        stall_back  = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        if (RST) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (ext_stall) begin
            stall_front = 1'b1;
            stall_back  = 1'b1;
        end else if (redirect3) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (hz_stall) begin
            stall_front = 1'b1;
            flush_ex    = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= HZ_RUN;
            ls_cnt       <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_front && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (!ext_stall) begin
                if (redirect3) begin
                    if (flush_events != '1)
                        flush_events <= flush_events + 1'b1;
                    state  <= HZ_RUN;
                    ls_cnt <= '0;
                end else if (state == HZ_LOAD_STALL) begin
                    if (ls_cnt == '0) state  <= HZ_RUN;
                    else              ls_cnt <= ls_cnt - 1'b1;
                end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                    state  <= HZ_LOAD_STALL;
                    ls_cnt <= LS_RELOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench: one DUT with single-cycle load stalls, one with three.
module tb_pipeline_hazard_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] ra1_2, ra2_2, ra1_3, ra2_3, wa3, wa4, wa5;
    logic       use_ra1_2, use_ra2_2, reg_we3, mem_read3, reg_we4, reg_we5, redirect3, ext_stall;

    logic        sf1, sb1, fi1, fe1, sf3, sb3, fi3, fe3;
    logic [1:0]  fa1, fb1, fa3, fb3;
    logic [15:0] sc1, fv1, sc3, fv3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_sequencer #(.LOAD_STALL_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .ra1_2(ra1_2), .ra2_2(ra2_2), .use_ra1_2(use_ra1_2), .use_ra2_2(use_ra2_2),
        .ra1_3(ra1_3), .ra2_3(ra2_3), .wa3(wa3), .reg_we3(reg_we3), .mem_read3(mem_read3),
        .wa4(wa4), .reg_we4(reg_we4), .wa5(wa5), .reg_we5(reg_we5), .redirect3(redirect3), .ext_stall(ext_stall),
        .stall_front(sf1), .stall_back(sb1), .flush_id(fi1), .flush_ex(fe1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cycles(sc1), .flush_events(fv1));

    pipeline_hazard_sequencer #(.LOAD_STALL_CYCLES(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .ra1_2(ra1_2), .ra2_2(ra2_2), .use_ra1_2(use_ra1_2), .use_ra2_2(use_ra2_2),
        .ra1_3(ra1_3), .ra2_3(ra2_3), .wa3(wa3), .reg_we3(reg_we3), .mem_read3(mem_read3),
        .wa4(wa4), .reg_we4(reg_we4), .wa5(wa5), .reg_we5(reg_we5), .redirect3(redirect3), .ext_stall(ext_stall),
        .stall_front(sf3), .stall_back(sb3), .flush_id(fi3), .flush_ex(fe3), .fwd_a(fa3), .fwd_b(fb3),
        .stall_cycles(sc3), .flush_events(fv3));

    task automatic clr();
        ra1_2 = '0; ra2_2 = '0; ra1_3 = '0; ra2_3 = '0; wa3 = '0; wa4 = '0; wa5 = '0;
        use_ra1_2 = 0; use_ra2_2 = 0; reg_we3 = 0; mem_read3 = 0; reg_we4 = 0; reg_we5 = 0;
        redirect3 = 0; ext_stall = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        clr(); RST = 1'b1; tick(); RST = 1'b0;
    endtask

    task automatic set_load_use();
        mem_read3 = 1; reg_we3 = 1; wa3 = 5'd3; use_ra1_2 = 1; ra1_2 = 5'd3;
    endtask

    task automatic test_reset();
        clr(); RST = 1'b1;
        ext_stall = 1; ra1_3 = 5'd5; wa4 = 5'd5; reg_we4 = 1;
        tick(); #1;
        checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL rst_stall_front: got %0h exp 0", sf1); end
        checks++; if (sb1 !== 1'b0) begin errors++; $display("FAIL rst_stall_back: got %0h exp 0", sb1); end
        checks++; if ({fi1, fe1} !== 2'b11) begin errors++; $display("FAIL rst_flush: got %b exp 11", {fi1, fe1}); end
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL rst_fwd_a: got %b exp 00", fa1); end
        checks++; if ({sc1, fv1, sc3, fv3} !== 64'd0) begin errors++; $display("FAIL rst_counters: got %h exp 0", {sc1, fv1, sc3, fv3}); end
        clr(); RST = 1'b0;
    endtask

    task automatic test_load_use();
        set_load_use(); #1;
        checks++; if ({sf1, sb1, fi1, fe1} !== 4'b1001) begin errors++; $display("FAIL lu_ctrl: got %b exp 1001", {sf1, sb1, fi1, fe1}); end
        tick(); clr();
        ra1_3 = 5'd3; wa5 = 5'd3; reg_we5 = 1; #1;
        checks++; if (fa1 !== 2'b10) begin errors++; $display("FAIL lu_fwd_wb: got %b exp 10", fa1); end
        checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL lu_release: got %0h exp 0", sf1); end
        checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp 1", sc1); end
        tick(); clr();
    endtask

    task automatic test_fwd_priority();
        wa4 = 5'd5; reg_we4 = 1; ra2_3 = 5'd5; wa5 = 5'd5; reg_we5 = 1; ra1_3 = 5'd7; #1;
        checks++; if (fb1 !== 2'b01) begin errors++; $display("FAIL fwd_mem_prio: got %b exp 01", fb1); end
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL fwd_a_none: got %b exp 00", fa1); end
        checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %0h exp 0", sf1); end
        reg_we4 = 0; #1;
        checks++; if (fb1 !== 2'b10) begin errors++; $display("FAIL fwd_wb_only: got %b exp 10", fb1); end
        reg_we5 = 0; #1;
        checks++; if (fb1 !== 2'b00) begin errors++; $display("FAIL fwd_rf: got %b exp 00", fb1); end
        clr();
    endtask

    task automatic test_redirect();
        set_load_use(); redirect3 = 1; #1;
        checks++; if ({sf1, sb1, fi1, fe1} !== 4'b0011) begin errors++; $display("FAIL rd_ctrl: got %b exp 0011", {sf1, sb1, fi1, fe1}); end
        tick(); clr(); #1;
        checks++; if (fv1 !== 16'd1) begin errors++; $display("FAIL rd_flush_cnt: got %0d exp 1", fv1); end
        ext_stall = 1; redirect3 = 1; #1;
        checks++; if ({sf1, sb1, fi1, fe1} !== 4'b1100) begin errors++; $display("FAIL ext_prio: got %b exp 1100", {sf1, sb1, fi1, fe1}); end
        tick(); clr(); #1;
        checks++; if (fv1 !== 16'd1) begin errors++; $display("FAIL ext_flush_hold: got %0d exp 1", fv1); end
        checks++; if (sc1 !== 16'd2) begin errors++; $display("FAIL ext_stall_cnt: got %0d exp 2", sc1); end
    endtask

    task automatic test_zero_reg();
        mem_read3 = 1; reg_we3 = 1; wa3 = 5'd0; use_ra1_2 = 1; ra1_2 = 5'd0;
        wa4 = 5'd0; reg_we4 = 1; ra1_3 = 5'd0; #1;
        checks++; if (sf1 !== 1'b0) begin errors++; $display("FAIL zero_no_stall: got %0h exp 0", sf1); end
        checks++; if (fa1 !== 2'b00) begin errors++; $display("FAIL zero_no_fwd: got %b exp 00", fa1); end
        clr();
    endtask

    task automatic test_multi_stall();
        logic [3:0] exp_sf, got_sf;
        do_reset();
        set_load_use(); #1;
        got_sf[0] = sf3;
        checks++; if ({sb3, fe3} !== 2'b01) begin errors++; $display("FAIL ms_c1_ctrl: got %b exp 01", {sb3, fe3}); end
        tick(); clr(); ext_stall = 1; #1;
        checks++; if ({sf3, sb3, fe3} !== 3'b110) begin errors++; $display("FAIL ms_c2_freeze: got %b exp 110", {sf3, sb3, fe3}); end
        tick(); clr(); #1;
        got_sf[1] = sf3;
        checks++; if (fe3 !== 1'b1) begin errors++; $display("FAIL ms_c3_bubble: got %0h exp 1", fe3); end
        tick(); #1; got_sf[2] = sf3;
        tick(); #1; got_sf[3] = sf3;
        exp_sf = 4'b0111;
        checks++; if (got_sf !== exp_sf) begin errors++; $display("FAIL ms_stall_seq: got %b exp %b", got_sf, exp_sf); end
        checks++; if (sc3 !== 16'd4) begin errors++; $display("FAIL ms_stall_cnt: got %0d exp 4", sc3); end
    endtask

    task automatic test_abort();
        do_reset();
        set_load_use(); tick(); clr();
        redirect3 = 1; #1;
        checks++; if ({sf3, fi3, fe3} !== 3'b011) begin errors++; $display("FAIL ab_flush: got %b exp 011", {sf3, fi3, fe3}); end
        tick(); clr(); #1;
        checks++; if (sf3 !== 1'b0) begin errors++; $display("FAIL ab_run: got %0h exp 0", sf3); end
        checks++; if (fv3 !== 16'd1) begin errors++; $display("FAIL ab_flush_cnt: got %0d exp 1", fv3); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        ext_stall = 1;
        repeat (65534) @(posedge CLK);
        #1;
        checks++; if (sc3 !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h exp fffe", sc3); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (sc3 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold%0d: got %h exp ffff", i, sc3); end
        end
        clr(); set_load_use(); tick(); clr(); #1;
        checks++; if (sf3 !== 1'b1) begin errors++; $display("FAIL mid_ls_stall: got %0h exp 1", sf3); end
        RST = 1'b1; #1;
        checks++; if ({sf3, sb3, fi3, fe3} !== 4'b0011) begin errors++; $display("FAIL mid_rst_ctrl: got %b exp 0011", {sf3, sb3, fi3, fe3}); end
        tick(); RST = 1'b0; #1;
        checks++; if (sf3 !== 1'b0) begin errors++; $display("FAIL mid_rst_run: got %0h exp 0", sf3); end
        checks++; if ({sc3, fv3} !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %h exp 0", {sc3, fv3}); end
    endtask

    initial begin
        clr(); RST = 1'b1;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect();
        test_zero_reg();
        test_multi_stall();
        test_abort();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Central hazard controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Generates per-cycle stall, flush and forwarding-select controls for the pipeline registers and the EX-stage operand muxes.
- Sequences multi-cycle load-use stalls with a down-counter.
- Gives jump/branch redirects resolved in EX and external freeze requests a defined priority.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register address width (matches instruction register fields)
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 16, performance counter width
ZERO_REG_HARDWIRED, 1, when 1, register address 0 never creates a hazard or forward

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ra1_2  in  REG_ADDR_W  ID-stage source address A
ra2_2  in  REG_ADDR_W  ID-stage source address B
use_ra1_2  in  1  ID instruction reads source A
use_ra2_2  in  1  ID instruction reads source B
ra1_3  in  REG_ADDR_W  EX-stage source address A
ra2_3  in  REG_ADDR_W  EX-stage source address B
wa3  in  REG_ADDR_W  EX-stage destination
reg_we3  in  1  EX instruction writes the register file
mem_read3  in  1  EX instruction is a load
wa4  in  REG_ADDR_W  MEM-stage destination
reg_we4  in  1  MEM instruction writes the register file
wa5  in  REG_ADDR_W  WB-stage destination
reg_we5  in  1  WB instruction writes the register file
redirect3  in  1  jump taken or branch taken, resolved in EX
ext_stall  in  1  freeze request from a multi-cycle resource
stall_front  out  1  hold PC and the IF/ID register
stall_back  out  1  hold the ID/EX, EX/MEM and MEM/WB registers
flush_id  out  1  clear the IF/ID register (bubble)
flush_ex  out  1  clear the ID/EX register (bubble)
fwd_a  out  2  EX operand A select: 00 register file, 01 MEM result, 10 WB result
fwd_b  out  2  EX operand B select, same encoding
stall_cycles  out  CNT_W  count of cycles with stall_front=1
flush_events  out  CNT_W  count of redirects taken

Behaviour:
- Reset (RST=1 at a clock edge): state <= RUN, counter <= 0, both perf counters <= 0. While RST=1 the combinational outputs are: stall_front=0, stall_back=0, flush_id=1, flush_ex=1, fwd_a=fwd_b=00.
- The state register is the only control state. States: RUN, LOAD_STALL. All stall/flush/fwd outputs are combinational from state and inputs, so they take effect in the same cycle.
- Matching rules:
  - match(x,w,we) = we & (x==w) & !(ZERO_REG_HARDWIRED & w==0).
  - load_use = mem_read3 & reg_we3 & ((use_ra1_2 & match(ra1_2,wa3,1)) | (use_ra2_2 & match(ra2_2,wa3,1))).
- Forwarding is independent of state:
  - fwd_a = 01 if match(ra1_3,wa4,reg_we4); else 10 if match(ra1_3,wa5,reg_we5); else 00. MEM has priority over WB.
  - fwd_b is the same rule using ra2_3.
- Priority per cycle: ext_stall > redirect3 > load hazard.
- ext_stall=1:
  - stall_front=1, stall_back=1, no flush.
  - State, counter and perf counters hold; stall_cycles still increments.
- RUN, redirect3=1:
  - flush_id=1, flush_ex=1, stalls 0.
  - flush_events increments. The state stays RUN.
- RUN, load_use=1:
  - stall_front=1, flush_ex=1 (bubble into EX), stall_back=0.
  - If LOAD_STALL_CYCLES>1: state <= LOAD_STALL and counter <= LOAD_STALL_CYCLES-2.
  - If LOAD_STALL_CYCLES=1: stay in RUN; the load then forwards from WB via 10.
- LOAD_STALL:
  - Same outputs as a RUN load stall.
  - When counter==0, state <= RUN; otherwise counter decrements.
  - redirect3=1 in this state aborts the stall: flush outputs as in RUN, state <= RUN, counter <= 0.
- Perf counters saturate at all-ones with no wrap.
- Invariant: stall_back=1 only when ext_stall=1.

Decomposition:
- In the shared typedefs package: fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and hz_state_t enum (HZ_RUN, HZ_LOAD_STALL). The Mux3x1 select and this block both use fwd_sel_t.
- One natural sub-module: fwd_select. It performs the per-operand comparison and is instantiated twice, for A and B.

Test Plan:
- Load r3 in EX (mem_read3=1, wa3=3) with ID add reading ra1_2=3 -> 1 cycle of stall_front=1, flush_ex=1. The next cycle the EX consumer sees fwd_a=10 with wa5=3.
- Back-to-back ALU ops: wa4=5, reg_we4=1, ra2_3=5, with wa5=5, reg_we5=1 also set -> fwd_b=01 (MEM priority), no stall.
- redirect3=1 while load_use=1 in the same cycle -> flush_id=1, flush_ex=1, stall_front=0, flush_events +1.
- LOAD_STALL_CYCLES=3, load-use hazard -> 3 consecutive stall cycles, then RUN. Raise ext_stall on the 2nd cycle -> that cycle holds everything and the total extends to 4.
- wa3=0 load with ra1_2=0 and ZERO_REG_HARDWIRED=1 -> no stall. Also wa4=0 with reg_we4=1 and ra1_3=0 -> fwd_a=00.
- Preload stall_cycles at 16'hFFFE, hold ext_stall for 3 cycles -> value stays 16'hFFFF. Assert RST mid-LOAD_STALL -> counters 0, state RUN, flushes=1 during reset.
